mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter sharing the data read port and the single write port of the dual-port main memory between the pipeline memory stage and a DMA/loader requester. Sits between the memory-stage control logic and the main memory. The instruction-fetch read port is not routed through this block. Pipeline accesses are single-beat; DMA accesses are multi-beat bursts to consecutive word addresses, with a starvation guard so DMA always makes progress.

## Interface
- ADDR_W, 32, address width (word addresses)
- DATA_W, 32, data width
- LEN_W, 5, width of burst-length field; a burst is d_len+1 beats
- STARVE_LIMIT, 4, consecutive contested pipeline wins before DMA is forced (1..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- p_req  in  1  pipeline access request, held until p_gnt
- p_we  in  1  1 = store, 0 = load
- p_addr  in  ADDR_W  pipeline address
- p_wdata  in  DATA_W  pipeline store data
- p_gnt  out  1  pipeline beat issued this cycle (combinational)
- p_rvalid  out  1  registered load data valid
- p_rdata  out  DATA_W  registered load data
- d_req  in  1  DMA burst request, held until first d_gnt
- d_we  in  1  burst direction, sampled at burst start
- d_addr  in  ADDR_W  burst start address, sampled at burst start
- d_len  in  LEN_W  beats minus one, sampled at burst start
- d_wdata  in  DATA_W  write data of current beat; DMA advances on d_gnt
- d_gnt  out  1  DMA beat issued this cycle (combinational)
- d_rvalid  out  1  registered DMA read data valid
- d_rdata  out  DATA_W  registered DMA read data
- d_done  out  1  one-cycle pulse, cycle after last beat
- m_raddr  out  ADDR_W  memory read address
- m_rdata  in  DATA_W  memory read data, combinational from m_raddr
- m_waddr  out  ADDR_W  memory write address
- m_wdata  out  DATA_W  memory write data
- m_wen  out  1  memory write enable

## Operation
- FSM states: IDLE, BURST. Registers: beat address, beats remaining, latched d_we, starve_cnt, read-return flags/data.
- At most one beat per cycle; p_gnt and d_gnt never both high.
- IDLE: p_req and (!d_req or starve_cnt < STARVE_LIMIT) -> pipeline beat. Otherwise d_req -> latch d_addr/d_we/d_len, issue first beat with d_gnt=1; if d_len=0 stay IDLE, else go to BURST.
- BURST: each cycle issue beat at address+1, decrement remaining; after final beat go to IDLE. The pipeline is stalled (p_gnt=0) unless preemption is compiled in.
- starve_cnt: increments (saturating) on a pipeline grant while d_req is high or a burst is pending; clears on any DMA beat or when d_req is low in IDLE.
- Beat issue: store drives m_waddr/m_wdata from the requester and m_wen=1. Load drives m_raddr; m_rdata is captured into p_rdata/d_rdata at the clock edge.
- No beat issued: m_wen=0 and m_raddr=m_waddr=m_wdata=0.
- Burst address wraps modulo 2^ADDR_W.

## Timing
- Grant: combinational, same cycle as request.
- Read latency: p_rvalid/d_rvalid high exactly 1 cycle after the granted load beat; rdata holds until the next valid.
- Write: performed at the edge ending the granted cycle.
- Burst of N beats with no preemption: d_gnt high N consecutive cycles, d_done 1 cycle after the last beat, coincident with the last d_rvalid on reads.
- d_req and p_req both rising in the same cycle with starve_cnt=0: the pipeline wins.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset asserted mid-burst: the burst is aborted with no d_done; the DMA must re-request.

## Configuration
- MEM_ARB_PREEMPT_EN defined: in BURST, p_req with starve_cnt < STARVE_LIMIT grants the pipeline. The DMA beat is withheld (d_gnt=0) and the burst address/count are held. The burst resumes in the next non-preempted cycle. starve_cnt still forces DMA progress.
- MEM_ARB_PREEMPT_EN undefined: a burst runs to completion and p_gnt=0 throughout BURST.

## Test plan
- Reset then pipeline store 0xDEADBEEF at addr 0x10, then load 0x10 -> m_wen=1 for one cycle; p_rvalid one cycle after load grant with p_rdata=0xDEADBEEF.
- DMA write burst d_addr=0x20, d_len=3, data 1..4 -> d_gnt 4 consecutive cycles at 0x20..0x23, d_done the next cycle, memory holds 1..4.
- Continuous p_req with d_req held, STARVE_LIMIT=4 -> 4 pipeline grants then 1 DMA beat, repeating.
- p_req during an 8-beat read burst -> undefined macro: p_gnt=0 for 7 cycles after the first beat. Defined: pipeline granted, burst paused, and all 8 beats return correct data.
- Burst at d_addr=0xFFFFFFFE, d_len=2 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- rst asserted low at beat 2 of a 6-beat burst -> all outputs 0 immediately, no d_done; a fresh d_req is serviced normally after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the memory data-read and write ports between the pipeline (single beats) and a DMA requester (bursts)
//   Optional feature macro: MEM_ARB_PREEMPT_EN (the pipeline may preempt beats in the middle of a DMA burst)
//   clk, rst (async, active-low)
//   p_req/p_we/p_addr/p_wdata -> p_gnt (comb), p_rvalid/p_rdata (registered)
//   d_req/d_we/d_addr/d_len/d_wdata -> d_gnt (comb), d_rvalid/d_rdata/d_done (registered)
//   m_raddr/m_rdata (comb read), m_waddr/m_wdata/m_wen (write at the edge)
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] m_raddr,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wen
);
    typedef enum logic {IDLE, BURST} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] b_addr;
    logic [LEN_W-1:0]  b_rem;
    logic              b_we;
    logic [3:0]        starve_cnt;
    logic              starve_ok, beat, beat_we, last_beat;
    logic [ADDR_W-1:0] beat_addr;

    assign starve_ok = starve_cnt < LIMIT;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = d_gnt ? (last_beat ? IDLE : BURST) : state;

    // Grants are gated by rst so every output drops the moment reset asserts.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                p_gnt = p_req && (!d_req || starve_ok);
                d_gnt = d_req && !p_gnt;
            end else begin
`ifdef MEM_ARB_PREEMPT_EN
                p_gnt = p_req && starve_ok;
`endif
                d_gnt = !p_gnt;
            end
        end
        beat      = p_gnt || d_gnt;
        beat_we   = p_gnt ? p_we : (state == IDLE) ? d_we : b_we;
        beat_addr = p_gnt ? p_addr : (state == IDLE) ? d_addr : b_addr;
        // In IDLE the beat being issued is the first of a new burst.
        last_beat = (state == IDLE) ? (d_len == '0) : (b_rem == LEN_W'(1));
        m_wen     = beat && beat_we;
        m_waddr   = m_wen ? beat_addr : '0;
        m_wdata   = m_wen ? (p_gnt ? p_wdata : d_wdata) : '0;
        m_raddr   = (beat && !beat_we) ? beat_addr : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_addr     <= '0;
            b_rem      <= '0;
            b_we       <= 1'b0;
            starve_cnt <= '0;
            p_rvalid   <= 1'b0;
            p_rdata    <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_done     <= 1'b0;
        end else begin
            // b_rem counts the beats still owed after the one issued now.
            if (d_gnt) begin
                b_addr <= beat_addr + ADDR_W'(1);
                b_rem  <= (state == IDLE) ? d_len : b_rem - LEN_W'(1);
                b_we   <= (state == IDLE) ? d_we : b_we;
            end
            starve_cnt <= d_gnt ? '0 :
                          (p_gnt && (d_req || state == BURST)) ? ((starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1) :
                          (state == IDLE && !d_req) ? '0 : starve_cnt;
            p_rvalid <= p_gnt && !p_we;
            if (p_gnt && !p_we) p_rdata <= m_rdata;
            d_rvalid <= d_gnt && !beat_we;
            if (d_gnt && !beat_we) d_rdata <= m_rdata;
            d_done <= d_gnt && last_beat;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter with a 256-word memory and a reference model
module tb_mem_port_arbiter;
    localparam int SL = 4;
    logic clk = 1'b0, rst;
    logic p_req, p_we, p_gnt, p_rvalid;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic d_req, d_we, d_gnt, d_rvalid, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [4:0] d_len;
    logic [31:0] m_raddr, m_rdata, m_waddr, m_wdata;
    logic m_wen;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int errors = 0, checks = 0;

    // reference model state
    logic [31:0] bq[$];
    logic bwe_m;
    int starve;
    logic e_pg, e_dg, e_we, e_last, e_first, ep_rv, ed_rv, e_done;
    logic [31:0] e_addr, e_wdata, ep_rd, ed_rd;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(5), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .m_raddr(m_raddr), .m_rdata(m_rdata), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wen(m_wen)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'hA5A50000;
    endfunction

    assign m_rdata = mem[m_raddr[7:0]];
    always @(posedge clk)
        if (!rst) for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
        else if (m_wen) mem[m_waddr[7:0]] <= m_wdata;

    task automatic idle_inputs();
        p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_len = 0; d_wdata = 0;
    endtask

    task automatic model_reset();
        bq.delete(); starve = 0; bwe_m = 0;
        ep_rv = 0; ep_rd = 0; ed_rv = 0; ed_rd = 0; e_done = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    // Arbitration decision for the current cycle, from the pending-burst address queue.
    task automatic model_eval();
        bit pend;
        pend = bq.size() != 0;
        if (!pend) begin
            e_pg = p_req && (!d_req || starve < SL);
            e_dg = !e_pg && d_req;
        end else begin
`ifdef MEM_ARB_PREEMPT_EN
            e_pg = p_req && starve < SL;
`else
            e_pg = 1'b0;
`endif
            e_dg = !e_pg;
        end
        e_first = e_dg && !pend;
        e_addr  = e_pg ? p_addr : !pend ? d_addr : bq[0];
        e_we    = e_pg ? p_we : !pend ? d_we : bwe_m;
        e_wdata = e_pg ? p_wdata : d_wdata;
        e_last  = e_dg && (!pend ? (d_len == 0) : (bq.size() == 1));
    endtask

    task automatic model_commit();
        bit pend;
        pend = bq.size() != 0;
        ep_rv = e_pg && !e_we;
        if (ep_rv) ep_rd = ref_mem[e_addr[7:0]];
        ed_rv = e_dg && !e_we;
        if (ed_rv) ed_rd = ref_mem[e_addr[7:0]];
        e_done = e_last;
        if ((e_pg || e_dg) && e_we) ref_mem[e_addr[7:0]] = e_wdata;
        if (e_dg) begin
            if (!pend) begin
                bwe_m = d_we;
                for (int i = 1; i <= int'(d_len); i++) bq.push_back(d_addr + 32'(i));
            end else void'(bq.pop_front());
        end
        if (e_dg) starve = 0;
        else if (e_pg && (d_req || pend)) starve = (starve < 15) ? starve + 1 : 15;
        else if (!pend && !d_req) starve = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        p_req = 1; p_we = 1; p_addr = 32'h10; p_wdata = 32'h1;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_len = 5'd3;
        @(negedge clk); #1;
        checks++; if ({p_gnt, d_gnt, m_wen} !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b want=000", {p_gnt, d_gnt, m_wen}); end
        checks++; if ({p_rvalid, d_rvalid, d_done} !== 3'b000) begin errors++; $display("FAIL reset_valid got=%b want=000", {p_rvalid, d_rvalid, d_done}); end
        checks++; if ({m_raddr, m_waddr, m_wdata} !== 96'd0) begin errors++; $display("FAIL reset_mem_bus got=%h want=0", {m_raddr, m_waddr, m_wdata}); end
        checks++; if ({p_rdata, d_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got=%h want=0", {p_rdata, d_rdata}); end
        idle_inputs();
        @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    task automatic test_pipe_store_load();
        reset_dut();
        p_req = 1; p_we = 1; p_addr = 32'h10; p_wdata = 32'hDEADBEEF; #1;
        checks++; if ({p_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL store_gnt got=%b want=10", {p_gnt, d_gnt}); end
        checks++; if ({m_wen, m_waddr, m_wdata, m_raddr} !== {1'b1, 32'h10, 32'hDEADBEEF, 32'h0}) begin errors++; $display("FAIL store_bus got=%b/%h/%h/%h want=1/10/deadbeef/0", m_wen, m_waddr, m_wdata, m_raddr); end
        ref_mem[16] = 32'hDEADBEEF;
        @(negedge clk);
        p_we = 0; p_wdata = 0; #1;
        checks++; if ({p_gnt, m_wen, m_raddr, p_rvalid} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin errors++; $display("FAIL load_issue got=%b/%b/%h/%b want=1/0/10/0", p_gnt, m_wen, m_raddr, p_rvalid); end
        @(negedge clk);
        p_req = 0; #1;
        checks++; if ({p_rvalid, p_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL load_data got=%b/%h want=1/deadbeef", p_rvalid, p_rdata); end
        @(negedge clk); #1;
        checks++; if ({p_rvalid, p_rdata} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL load_hold got=%b/%h want=0/deadbeef", p_rvalid, p_rdata); end
    endtask

    task automatic test_dma_write_burst();
        reset_dut();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_len = 5'd3;
        for (int i = 0; i < 4; i++) begin
            d_wdata = 32'(i + 1); #1;
            checks++;
            if ({p_gnt, d_gnt, m_wen, m_waddr, m_wdata, d_done} !== {1'b0, 1'b1, 1'b1, 32'h20 + 32'(i), 32'(i + 1), 1'b0}) begin
                errors++; $display("FAIL dma_wr_beat%0d got=%b%b%b/%h/%h/%b want=011/%h/%h/0", i, p_gnt, d_gnt, m_wen, m_waddr, m_wdata, d_done, 32'h20 + 32'(i), i + 1);
            end
            ref_mem[32 + i] = 32'(i + 1);
            @(negedge clk);
            d_req = 0; d_we = 0; d_addr = 0; d_len = 0;
        end
        #1;
        checks++; if ({d_gnt, d_done, m_wen} !== 3'b010) begin errors++; $display("FAIL dma_wr_done got=%b want=010", {d_gnt, d_done, m_wen}); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[32 + i] !== 32'(i + 1)) begin errors++; $display("FAIL dma_wr_mem%0d got=%h want=%h", i, mem[32 + i], i + 1); end
        end
        @(negedge clk); #1;
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL dma_wr_done_pulse got=%b want=0", d_done); end
    endtask

    task automatic test_starvation();
        logic want_d;
        reset_dut();
        p_req = 1; p_we = 0; p_addr = 32'h10;
        d_req = 1; d_we = 0; d_addr = 32'h30; d_len = 0;
        for (int c = 0; c < 3 * (SL + 1); c++) begin
            #1;
            want_d = (c % (SL + 1)) == SL;
            checks++; if ({p_gnt, d_gnt} !== {!want_d, want_d}) begin errors++; $display("FAIL starve_c%0d got=%b%b want=%b%b", c, p_gnt, d_gnt, !want_d, want_d); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_preempt();
        int beats, rets, pg_early, pg_total, done_c;
        bit done;
        reset_dut();
        d_req = 1; d_we = 0; d_addr = 32'h40; d_len = 5'd7; #1;
        checks++; if ({p_gnt, d_gnt, m_raddr} !== {1'b0, 1'b1, 32'h40}) begin errors++; $display("FAIL preempt_first got=%b%b/%h want=01/40", p_gnt, d_gnt, m_raddr); end
        beats = 1; rets = 0; pg_early = 0; pg_total = 0; done = 0; done_c = -1;
        @(negedge clk);
        d_req = 0; p_req = 1; p_we = 0; p_addr = 32'h11;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (d_rvalid) begin
                checks++; if (d_rdata !== ref_mem[64 + rets]) begin errors++; $display("FAIL preempt_data%0d got=%h want=%h", rets, d_rdata, ref_mem[64 + rets]); end
                rets++;
            end
            if (d_done) begin done = 1; done_c = c; end
            if (d_gnt) begin
                checks++; if (m_raddr !== 32'h40 + 32'(beats)) begin errors++; $display("FAIL preempt_addr%0d got=%h want=%h", beats, m_raddr, 32'h40 + 32'(beats)); end
                beats++;
            end
            if (p_gnt) begin pg_total++; if (c < 7) pg_early++; end
            @(negedge clk);
        end
        p_req = 0;
        checks++; if (!done) begin errors++; $display("FAIL preempt_timeout got=no_done want=done"); end
        checks++; if ({rets, beats} !== {32'd8, 32'd8}) begin errors++; $display("FAIL preempt_count got=rets%0d/beats%0d want=8/8", rets, beats); end
`ifdef MEM_ARB_PREEMPT_EN
        checks++; if (pg_early == 0) begin errors++; $display("FAIL preempt_pgnt got=%0d want=>0", pg_early); end
`else
        checks++; if (pg_early != 0) begin errors++; $display("FAIL preempt_stall got=%0d want=0", pg_early); end
        checks++; if (done_c != 7) begin errors++; $display("FAIL preempt_done_cycle got=%0d want=7", done_c); end
`endif
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        reset_dut();
        d_req = 1; d_we = 0; d_addr = 32'hFFFFFFFE; d_len = 5'd2;
        for (int i = 0; i < 3; i++) begin
            a = 32'hFFFFFFFE + 32'(i); #1;
            checks++; if ({d_gnt, m_raddr} !== {1'b1, a}) begin errors++; $display("FAIL wrap_beat%0d got=%b/%h want=1/%h", i, d_gnt, m_raddr, a); end
            @(negedge clk);
            d_req = 0;
        end
        #1;
        checks++; if ({d_done, d_rvalid, d_rdata} !== {1'b1, 1'b1, ref_mem[0]}) begin errors++; $display("FAIL wrap_done got=%b%b/%h want=11/%h", d_done, d_rvalid, d_rdata, ref_mem[0]); end
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        d_req = 1; d_we = 0; d_addr = 32'h60; d_len = 5'd5;
        @(negedge clk);
        d_req = 0;
        @(negedge clk); #1;
        checks++; if ({d_gnt, m_raddr} !== {1'b1, 32'h62}) begin errors++; $display("FAIL midrst_beat2 got=%b/%h want=1/62", d_gnt, m_raddr); end
        rst = 0; #1;
        checks++; if ({p_gnt, d_gnt, m_wen, p_rvalid, d_rvalid, d_done} !== 6'd0) begin errors++; $display("FAIL midrst_ctrl got=%b want=000000", {p_gnt, d_gnt, m_wen, p_rvalid, d_rvalid, d_done}); end
        checks++; if ({m_raddr, m_waddr, m_wdata, p_rdata, d_rdata} !== 160'd0) begin errors++; $display("FAIL midrst_data got=%h want=0", {m_raddr, m_waddr, m_wdata, p_rdata, d_rdata}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if ({d_gnt, d_done, d_rvalid} !== 3'b000) begin errors++; $display("FAIL midrst_quiet%0d got=%b want=000", c, {d_gnt, d_done, d_rvalid}); end
            @(negedge clk);
        end
        d_req = 1; d_we = 0; d_addr = 32'h05; d_len = 0; #1;
        checks++; if ({d_gnt, m_raddr} !== {1'b1, 32'h5}) begin errors++; $display("FAIL midrst_fresh got=%b/%h want=1/5", d_gnt, m_raddr); end
        @(negedge clk);
        d_req = 0; #1;
        checks++; if ({d_rvalid, d_done, d_rdata} !== {1'b1, 1'b1, ref_mem[5]}) begin errors++; $display("FAIL midrst_fresh_done got=%b%b/%h want=11/%h", d_rvalid, d_done, d_rdata, ref_mem[5]); end
    endtask

    task automatic test_random();
        bit drop_p, drop_d, wen;
        reset_dut();
        drop_p = 0; drop_d = 0;
        for (int c = 0; c < 800; c++) begin
            if (drop_p) p_req = 0;
            if (drop_d) d_req = 0;
            if (!p_req && $urandom_range(0, 1) == 1) begin
                p_req = 1; p_we = 1'($urandom_range(0, 1)); p_addr = $urandom; p_wdata = $urandom;
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_len = 5'($urandom_range(0, 5));
            end
            d_wdata = $urandom;
            #1;
            model_eval();
            wen = (e_pg || e_dg) && e_we;
            checks++; if ({p_gnt, d_gnt} !== {e_pg, e_dg}) begin errors++; $display("FAIL rnd_gnt c%0d got=%b%b want=%b%b", c, p_gnt, d_gnt, e_pg, e_dg); end
            checks++; if ({m_wen, m_waddr, m_wdata} !== {wen, wen ? e_addr : 32'h0, wen ? e_wdata : 32'h0}) begin errors++; $display("FAIL rnd_wr c%0d got=%b/%h/%h want=%b/%h/%h", c, m_wen, m_waddr, m_wdata, wen, wen ? e_addr : 32'h0, wen ? e_wdata : 32'h0); end
            checks++; if (m_raddr !== (((e_pg || e_dg) && !e_we) ? e_addr : 32'h0)) begin errors++; $display("FAIL rnd_raddr c%0d got=%h want=%h", c, m_raddr, ((e_pg || e_dg) && !e_we) ? e_addr : 32'h0); end
            checks++; if ({p_rvalid, d_rvalid, d_done} !== {ep_rv, ed_rv, e_done}) begin errors++; $display("FAIL rnd_valid c%0d got=%b want=%b", c, {p_rvalid, d_rvalid, d_done}, {ep_rv, ed_rv, e_done}); end
            checks++; if ({p_rdata, d_rdata} !== {ep_rd, ed_rd}) begin errors++; $display("FAIL rnd_rdata c%0d got=%h/%h want=%h/%h", c, p_rdata, d_rdata, ep_rd, ed_rd); end
            drop_p = e_pg;
            drop_d = e_first;
            model_commit();
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_pipe_store_load();
        test_dma_write_burst();
        test_starvation();
        test_preempt();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
